// File: rtl/fc_argmax_head_if.sv
// rtl/fc_argmax_head_if.sv - weight-load, feature-input and result signals of fc_argmax_head
interface fc_argmax_head_if #(
   parameter int N_CLASS = 10
);
   localparam int IDX_W = $clog2(N_CLASS);

   logic                  load;
   logic                  w_valid;
   logic [31:0]           w_in;
   logic                  input_valid;
   logic                  sof;
   logic [15:0][31:0]     d_in;
   logic                  load_weight_done;
   logic                  busy;
   logic                  output_valid;
   logic                  o_sof;
   logic [IDX_W-1:0]      class_idx;
   logic [31:0]           max_score;
   logic                  drop;

   modport slave (
      input  load, w_valid, w_in, input_valid, sof, d_in,
      output load_weight_done, busy, output_valid, o_sof, class_idx, max_score, drop
   );

   modport master (
      output load, w_valid, w_in, input_valid, sof, d_in,
      input  load_weight_done, busy, output_valid, o_sof, class_idx, max_score, drop
   );
endinterface

// File: rtl/fc_argmax_head.sv
// rtl/fc_argmax_head.sv - Q16.16 fully-connected layer with argmax, one MAC per cycle
// Optional FC_SAT_EN: saturate the narrowed 32-bit score instead of wrapping.
module fc_argmax_head #(
   parameter int N_CLASS = 10,
   parameter int FRAC    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   fc_argmax_head_if.slave    bus
);
   localparam int DEPTH  = N_CLASS * 17;
   localparam int IDX_W  = $clog2(N_CLASS);
   localparam int CNT_W  = $clog2(DEPTH + 1);
   localparam int ADDR_W = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_BIAS, S_DONE} state_t;

   state_t                   r_state;
   state_t                   w_next;
   logic [31:0]              r_wmem [DEPTH];
   logic                     r_load_d;
   logic [CNT_W-1:0]         r_cnt;
   logic                     r_done;
   logic [15:0][31:0]        r_d;
   logic                     r_sof;
   logic [3:0]               r_k;
   logic [IDX_W-1:0]         r_cls;
   logic [ADDR_W-1:0]        r_raddr;
   logic signed [63:0]       r_acc;
   logic [IDX_W-1:0]         r_best_idx;
   logic signed [31:0]       r_best_score;
   logic                     r_out_valid;
   logic                     r_o_sof;
   logic [IDX_W-1:0]         r_class_idx;
   logic [31:0]              r_max_score;
   logic                     r_drop;

   logic                     w_load_rise;
   logic [CNT_W-1:0]         w_wr_addr;
   logic                     w_wr_en;
   logic                     w_accept;
   logic signed [31:0]       w_rd;
   logic signed [31:0]       w_d_sel;
   logic signed [63:0]       w_prod;
   logic signed [63:0]       w_sum;
   logic signed [31:0]       w_score;
   logic                     w_better;

   // A fresh load session restarts at address 0 even if the first word arrives on the rising edge.
   assign w_load_rise = bus.load & ~r_load_d;
   assign w_wr_addr   = w_load_rise ? '0 : r_cnt;
   assign w_wr_en     = bus.load & bus.w_valid & (w_wr_addr < CNT_W'(DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_load_d <= 1'b0;
         r_cnt    <= '0;
         r_done   <= 1'b0;
      end else begin
         r_load_d <= bus.load;
         if (w_load_rise) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
         end
         if (w_wr_en) begin
            r_cnt <= w_wr_addr + CNT_W'(1);
            if (w_wr_addr == CNT_W'(DEPTH - 1))
               r_done <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en)
         r_wmem[w_wr_addr[ADDR_W-1:0]] <= bus.w_in;
   end

   assign w_rd    = r_wmem[r_raddr];
   assign w_d_sel = r_d[r_k];
   assign w_prod  = {{32{w_d_sel[31]}}, w_d_sel} * {{32{w_rd[31]}}, w_rd};
   assign w_sum   = r_acc + ({{32{w_rd[31]}}, w_rd} << FRAC);

`ifdef FC_SAT_EN
   logic signed [63:0] w_shift;
   assign w_shift = w_sum >>> FRAC;
   always_comb begin
      w_score = w_shift[31:0];
      if (!((&w_shift[63:31]) | ~(|w_shift[63:31])))
         w_score = w_shift[63] ? 32'sh80000000 : 32'sh7FFFFFFF;
   end
`else
   assign w_score = 32'(w_sum >>> FRAC);
`endif

   // Strict greater-than keeps the lowest index on ties.
   assign w_better = (r_cls == '0) | (w_score > r_best_score);
   assign w_accept = (r_state == S_IDLE) & ~r_out_valid & ~bus.load & r_done & bus.input_valid;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_next = S_MAC;
         S_MAC:  if (r_k == 4'd15) w_next = S_BIAS;
         S_BIAS: w_next = (r_cls == IDX_W'(N_CLASS - 1)) ? S_DONE : S_MAC;
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_d          <= '0;
         r_sof        <= 1'b0;
         r_k          <= '0;
         r_cls        <= '0;
         r_raddr      <= '0;
         r_acc        <= '0;
         r_best_idx   <= '0;
         r_best_score <= '0;
         r_out_valid  <= 1'b0;
         r_o_sof      <= 1'b0;
         r_class_idx  <= '0;
         r_max_score  <= '0;
         r_drop       <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_out_valid <= 1'b0;
         if (bus.input_valid & ~w_accept)
            r_drop <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_d     <= bus.d_in;
                  r_sof   <= bus.sof;
                  r_k     <= '0;
                  r_cls   <= '0;
                  r_raddr <= '0;
               end
            end
            S_MAC: begin
               r_acc   <= (r_k == 4'd0) ? w_prod : r_acc + w_prod;
               r_k     <= r_k + 4'd1;
               r_raddr <= r_raddr + ADDR_W'(1);
            end
            S_BIAS: begin
               if (w_better) begin
                  r_best_idx   <= r_cls;
                  r_best_score <= w_score;
               end
               r_cls   <= r_cls + IDX_W'(1);
               r_raddr <= r_raddr + ADDR_W'(1);
               r_k     <= '0;
            end
            S_DONE: begin
               r_out_valid <= 1'b1;
               r_class_idx <= r_best_idx;
               r_max_score <= r_best_score;
               r_o_sof     <= r_sof;
            end
            default: ;
         endcase
      end
   end

   assign bus.load_weight_done = r_done;
   assign bus.busy             = (r_state != S_IDLE) | r_out_valid;
   assign bus.output_valid     = r_out_valid;
   assign bus.o_sof            = r_o_sof;
   assign bus.class_idx        = r_class_idx;
   assign bus.max_score        = r_max_score;
   assign bus.drop             = r_drop;
endmodule

// File: tb/tb_fc_argmax_head.sv
// tb/tb_fc_argmax_head.sv - randomized self-checking bench for fc_argmax_head against a reference model
module tb_fc_argmax_head;
   localparam int NC    = 10;
   localparam int DEPTH = NC * 17;
   localparam int LAT   = 17 * NC + 2;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   int   wm [DEPTH];
   int   dv [16];

   fc_argmax_head_if #(.N_CLASS(NC)) bus ();

   fc_argmax_head #(.N_CLASS(NC), .FRAC(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model(output int idx, output logic [31:0] sc);
      longint acc;
      longint sh;
      logic [31:0] s;
      idx = 0;
      sc  = '0;
      for (int c = 0; c < NC; c++) begin
         acc = 0;
         for (int k = 0; k < 16; k++)
            acc += longint'(dv[k]) * longint'(wm[c*17+k]);
         acc += longint'(wm[c*17+16]) <<< 16;
         sh = acc >>> 16;
`ifdef FC_SAT_EN
         if (sh > 64'sh7FFFFFFF)       s = 32'h7FFFFFFF;
         else if (sh < -64'sh80000000) s = 32'h80000000;
         else                          s = sh[31:0];
`else
         s = sh[31:0];
`endif
         if (c == 0 || $signed(s) > $signed(sc)) begin
            sc  = s;
            idx = c;
         end
      end
   endfunction

   task automatic load_all();
      bus.load    = 1'b1;
      bus.w_valid = 1'b0;
      tick();
      for (int i = 0; i < DEPTH; i++) begin
         if ($urandom_range(3) == 0) begin
            bus.w_valid = 1'b0;
            tick();
         end
         bus.w_valid = 1'b1;
         bus.w_in    = wm[i];
         tick();
      end
      bus.w_in = $urandom;
      tick();
      bus.w_valid = 1'b0;
      bus.load    = 1'b0;
      tick();
      check("load_done", 64'(bus.load_weight_done), 64'd1);
   endtask

   task automatic run_check(input string tag, input bit drop_probe);
      int          n;
      int          e_idx;
      logic [31:0] e_sc;
      logic        s;
      model(e_idx, e_sc);
      s = 1'($urandom);
      for (int k = 0; k < 16; k++) bus.d_in[k] = dv[k];
      bus.sof         = s;
      bus.input_valid = 1'b1;
      tick();
      bus.input_valid = 1'b0;
      bus.sof         = 1'b0;
      check({tag, "_busy"}, 64'(bus.busy), 64'd1);
      n = 1;
      while (!bus.output_valid && n < 400) begin
         if (drop_probe) bus.input_valid = (n == 4);
         tick();
         n++;
      end
      bus.input_valid = 1'b0;
      check({tag, "_latency"}, 64'(n), 64'(LAT));
      check({tag, "_idx"}, 64'(bus.class_idx), 64'(e_idx));
      check({tag, "_score"}, 64'(bus.max_score), 64'(e_sc));
      check({tag, "_osof"}, 64'(bus.o_sof), 64'(s));
      if (drop_probe) check({tag, "_drop"}, 64'(bus.drop), 64'd1);
      tick();
      check({tag, "_ovpulse"}, 64'(bus.output_valid), 64'd0);
      check({tag, "_hold"}, 64'(bus.max_score), 64'(e_sc));
   endtask

   task automatic clear_all();
      for (int i = 0; i < DEPTH; i++) wm[i] = 0;
      for (int k = 0; k < 16; k++) dv[k] = 0;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_done"},  64'(bus.load_weight_done), 64'd0);
      check({tag, "_busy"},  64'(bus.busy), 64'd0);
      check({tag, "_ov"},    64'(bus.output_valid), 64'd0);
      check({tag, "_idx"},   64'(bus.class_idx), 64'd0);
      check({tag, "_score"}, 64'(bus.max_score), 64'd0);
      check({tag, "_drop"},  64'(bus.drop), 64'd0);
   endtask

   initial begin
      bit seen;
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      bus.load = 1'b0; bus.w_valid = 1'b0; bus.w_in = '0;
      bus.input_valid = 1'b0; bus.sof = 1'b0; bus.d_in = '0;
      tick(); tick();
      check_zero("reset");
      rst_n = 1'b1;
      tick();

      // beat before any weights are loaded
      bus.input_valid = 1'b1;
      tick();
      bus.input_valid = 1'b0;
      check("unloaded_drop", 64'(bus.drop), 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (bus.output_valid) seen = 1'b1;
      end
      check("unloaded_noov", 64'(seen), 64'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      check("drop_cleared", 64'(bus.drop), 64'd0);

      clear_all();
      for (int k = 0; k < 16; k++) begin wm[3*17+k] = 32'h00010000; dv[k] = 32'h00010000; end
      load_all();
      run_check("class3", 1'b0);

      clear_all();
      for (int k = 0; k < 16; k++) begin
         wm[2*17+k] = 32'h00008000; wm[5*17+k] = 32'h00008000; dv[k] = 32'h00020000;
      end
      load_all();
      run_check("tie", 1'b0);

      clear_all();
      for (int c = 0; c < NC; c++) wm[c*17+16] = -c * 32'h00010000;
      for (int k = 0; k < 16; k++) dv[k] = $urandom;
      load_all();
      run_check("negbias", 1'b0);
      wm[7*17+16] = 32'h00050000;
      load_all();
      run_check("bias7", 1'b0);

      clear_all();
      for (int k = 0; k < 16; k++) begin wm[k] = 32'h7FFF0000; dv[k] = 32'h7FFF0000; end
      load_all();
      run_check("sat16", 1'b0);
      clear_all();
      wm[0] = 32'h7FFF0000; dv[0] = 32'h7FFF0000;
      load_all();
      run_check("sat1pos", 1'b0);
      wm[0] = 32'h80010000;
      load_all();
      run_check("sat1neg", 1'b0);

      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < DEPTH; i++)
            wm[i] = (t < 3) ? int'($urandom) : ($signed($urandom_range(8)) - 4) * 32'sh00010000;
         for (int k = 0; k < 16; k++)
            dv[k] = (t < 3) ? int'($urandom) : ($signed($urandom_range(4)) - 2) * 32'sh00010000;
         load_all();
         run_check($sformatf("rand%0d", t), 1'b0);
      end

      run_check("dropmac", 1'b1);

      // asynchronous reset in the middle of the MAC phase
      for (int k = 0; k < 16; k++) bus.d_in[k] = dv[k];
      bus.input_valid = 1'b1;
      tick();
      bus.input_valid = 1'b0;
      for (int i = 0; i < 39; i++) tick();
      #2 rst_n = 1'b0;
      #1 check_zero("midrst");
      tick(); tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 250; i++) begin
         tick();
         if (bus.output_valid) seen = 1'b1;
      end
      check("aborted_noov", 64'(seen), 64'd0);
      load_all();
      run_check("rerun", 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fc_argmax_head.md
# fc_argmax_head

Classifier head that sits directly downstream of the CNN feature pipeline. It consumes the 16-channel, 32-bit globally average-pooled feature vector, computes an N_CLASS-output fully-connected layer in signed Q16.16 fixed point using one multiply-accumulate per cycle, and emits the winning class index and its score. Weights and biases are loaded serially before inference.

## Interface
- N_CLASS, 10, number of output classes (2..64)
- FRAC, 16, fractional bits of the fixed-point format
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- load  in  1  weight-load mode enable
- w_valid  in  1  qualifies w_in while load=1
- w_in  in  32  weight/bias word, signed Q16.16
- input_valid  in  1  feature vector beat valid
- sof  in  1  start-of-frame tag for the beat
- d_in  in  32x16  feature vector d_in[15:0], signed Q16.16
- load_weight_done  out  1  all N_CLASS*17 words loaded
- busy  out  1  FSM not in IDLE
- output_valid  out  1  one-cycle result strobe
- o_sof  out  1  sof of the vector that produced the result
- class_idx  out  $clog2(N_CLASS)  winning class
- max_score  out  32  winning score, signed Q16.16
- drop  out  1  sticky: an input beat was discarded

## Operation
- Reset: all outputs 0; FSM to IDLE; load counter 0. Weight memory contents are not cleared, but load_weight_done=0, so a reload is required.
- Weight memory: N_CLASS*17 words. Class c occupies addresses c*17+0..15 for weights w[c][0..15], then c*17+16 for the bias.
- Load:
  - A rising edge of load clears the counter and load_weight_done.
  - Each cycle with load && w_valid writes w_in at the counter address and increments the counter.
  - After word N_CLASS*17-1, load_weight_done=1; further words are ignored.
- Accept: in IDLE, with load=0, load_weight_done=1 and input_valid=1, the block latches d_in and sof and enters MAC.
- Drops: input_valid in any other condition (busy, load=1, or not loaded) discards the beat and sets drop. drop clears only on reset.
- FSM states: IDLE -> MAC -> BIAS -> (MAC for the next class | DONE) -> IDLE.
  - MAC: 16 cycles per class, one product per cycle, d_in[k]*w[c][k] accumulated into a 64-bit signed accumulator (cleared at class start).
  - BIAS: 1 cycle. Forms score = (acc + (bias <<< FRAC)) >>> FRAC, narrowed to 32 bits per Configuration, then compared.
  - DONE: 1 cycle. Asserts output_valid.
- Argmax:
  - Class 0 initialises the best index and score.
  - A later class replaces the best only if strictly greater, so ties resolve to the lowest index.
- class_idx, max_score and o_sof update at the DONE edge and hold until the next DONE or reset.

## Timing
- Accept edge E0; MAC/BIAS run for 17*N_CLASS cycles; output_valid is high for exactly the cycle following edge E0 + 17*N_CLASS + 1 (171 cycles for N_CLASS=10).
- busy=1 from E0+1 through the output_valid cycle inclusive.
- Back-to-back:
  - A new vector is accepted no earlier than the cycle after output_valid.
  - input_valid coincident with output_valid is dropped.
- Asserting load mid-inference does not abort the computation; the weights being read are undefined if written concurrently, and the software avoids this.
- Asynchronous reset mid-MAC aborts immediately, with no output_valid produced.

## Configuration
- FC_SAT_EN defined: the narrowed 32-bit score saturates to 0x7FFFFFFF / 0x80000000 on overflow.
- FC_SAT_EN undefined: the score is the low 32 bits of the shifted result (two's-complement wrap).

## Test plan
- Load: class 3 row all 0x00010000, every other word 0; d_in all 0x00010000 -> class_idx=3, max_score=0x00100000, output_valid at E0+171.
- Tie: classes 2 and 5 with identical rows of 0x00008000, rest 0; d_in all 0x00020000 -> class_idx=2, max_score=0x00100000.
- Bias and negatives: all weights 0, biases set to class c = -c*0x00010000 -> class_idx=0, max_score=0. Repeat with bias[7]=0x00050000 -> class_idx=7, max_score=0x00050000.
- Saturation: class 0 weights 0x7FFF0000, d_in 0x7FFF0000 -> max_score=0x7FFFFFFF with FC_SAT_EN. Without it, the score equals the wrapped low 32 bits.
- Drops:
  - input_valid at E0+5 during MAC -> ignored, drop=1, result unchanged.
  - input_valid before load_weight_done -> drop=1, no output_valid.
- Reset: rst low at E0+40, then reload and re-run -> no output_valid from the aborted run; all outputs 0 during reset; the second run produces the correct result at the expected latency.
